// File: rtl/ic_pkg.sv
// Shared interconnect package: default sizing, arbiter FSM states and
// one-hot/index conversion helpers used by the ic_* blocks.
package ic_pkg;

  localparam int IC_NM              = 3;
  localparam int IC_MAX_OUTSTANDING = 4;
  localparam int IC_HOT_W           = 32;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index width with a floor of one bit so single-entry configurations still elaborate.
  function automatic int ic_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [IC_HOT_W-1:0] ic_onehot(input logic [31:0] idx);
    logic [IC_HOT_W-1:0] v;
    v = '0;
    v[idx[4:0]] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] ic_index(input logic [IC_HOT_W-1:0] hot);
    logic [31:0] r;
    r = '0;
    for (int i = IC_HOT_W - 1; i >= 0; i--) begin
      if (hot[i]) r = 32'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ic_id_fifo.sv
// In-order requester-ID FIFO; pointers wrap at DEPTH so non-power-of-two
// depths work, and a simultaneous push/pop leaves the count unchanged.
module ic_id_fifo
  import ic_pkg::*;
#(
  parameter  int DEPTH = IC_MAX_OUTSTANDING,
  parameter  int W     = 2,
  localparam int PW    = ic_idx_w(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  id_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: entries are only read once the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= id_i;
  end

endmodule

// File: rtl/ic_req_arbiter.sv
// Round-robin arbiter sharing one device port among NM requesters, with an
// in-order ID FIFO that routes each device response back to its requester.
module ic_req_arbiter
  import ic_pkg::*;
#(
  parameter  int NM              = IC_NM,
  parameter  int MAX_OUTSTANDING = IC_MAX_OUTSTANDING,
  localparam int SW              = ic_idx_w(NM),
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  input  logic [NM-1:0] m_req,
  output logic [NM-1:0] m_gnt,
  output logic [NM-1:0] m_rsp,
  output logic          s_req,
  output logic [SW-1:0] s_sel,
  input  logic          s_gnt,
  input  logic          s_rsp,
  output logic [CW-1:0] outstanding,
  output logic          rsp_err
);

  arb_state_e          state_q, state_d;
  logic [SW-1:0]       lock_idx_q, lock_idx_d;
  logic [SW-1:0]       rr_q, rr_d;
  logic                rsp_err_q, rsp_err_d;
  logic [SW-1:0]       rr_pick;
  logic [SW-1:0]       sel;
  logic                handshake;
  logic                fifo_full, fifo_empty, fifo_pop;
  logic [SW-1:0]       fifo_head;
  logic [IC_HOT_W-1:0] gnt_hot, rsp_hot;

  always_comb begin
    int  idx;
    logic found;
    rr_pick = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NM; k++) begin
      idx = (int'(rr_q) + k) % NM;
      if (!found && m_req[idx]) begin
        found   = 1'b1;
        rr_pick = SW'(idx);
      end
    end
  end

  assign sel = (state_q == ARB_LOCKED) ? lock_idx_q : rr_pick;

  // Reset gates s_req directly so the device sees nothing while g_resetn is low.
  assign s_req     = g_resetn && (|m_req) && !fifo_full;
  assign s_sel     = s_req ? sel : '0;
  assign handshake = s_req && s_gnt;

  assign gnt_hot = ic_onehot(32'(s_sel));
  assign m_gnt   = handshake ? gnt_hot[NM-1:0] : '0;

  assign fifo_pop = s_rsp && !fifo_empty;
  assign rsp_hot  = ic_onehot(32'(fifo_head));
  assign m_rsp    = fifo_pop ? rsp_hot[NM-1:0] : '0;

  assign rsp_err  = rsp_err_q;

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    rsp_err_d  = rsp_err_q | (s_rsp & fifo_empty);
    case (state_q)
      ARB_OPEN: begin
        if (handshake) begin
          rr_d = s_sel;
        end else if (s_req) begin
          state_d    = ARB_LOCKED;
          lock_idx_d = s_sel;
        end
      end
      ARB_LOCKED: begin
        if (handshake) begin
          state_d = ARB_OPEN;
          rr_d    = s_sel;
        end
      end
      default: state_d = ARB_OPEN;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q    <= ARB_OPEN;
      lock_idx_q <= '0;
      rr_q       <= SW'(NM - 1);
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  ic_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (SW)
  ) u_id_fifo (
    .clk_i   (g_clk),
    .rst_ni  (g_resetn),
    .push_i  (handshake),
    .pop_i   (fifo_pop),
    .id_i    (s_sel),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .count_o (outstanding)
  );

endmodule
